// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single shared word memory.
// Every access runs IDLE -> ACCESS -> RESP; the winning port's inputs are latched at grant.
module mem_arbiter #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q;
    logic        lastGnt_q;
    logic        port_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        err0_q;
    logic        err1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        gnt_d;
    logic        outOfRange;
    logic [31:0] respData_d;

    // A lone requester wins outright; on a tie the port not served last wins.
    always_comb begin
        gnt_d = req1;
        if (req0 && req1) begin
            gnt_d = ~lastGnt_q;
        end
    end

    assign outOfRange = (addr_q >= DEPTH_W);
    assign respData_d = (!we_q && !outOfRange) ? mem_rdata : 32'h0;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (state_q == ACCESS) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_write = we_q & ~outOfRange;
            mem_read  = ~we_q & ~outOfRange;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            lastGnt_q <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q <= ACCESS;
                        port_q  <= gnt_d;
                        we_q    <= gnt_d ? we1 : we0;
                        addr_q  <= gnt_d ? addr1 : addr0;
                        wdata_q <= gnt_d ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    state_q   <= RESP;
                    lastGnt_q <= port_q;
                    if (port_q) begin
                        ack1_q   <= 1'b1;
                        err1_q   <= outOfRange;
                        rdata1_q <= respData_d;
                    end else begin
                        ack0_q   <= 1'b1;
                        err0_q   <= outOfRange;
                        rdata0_q <= respData_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
endmodule
